pipelined_lca_adder: RTL and testbench

//  Wide adder that splits WIDTH-bit operands into 4-bit slices and adds one slice per stage.

---
 rtl/pipelined_lca_adder.sv | 120 ++++++++++++
 tb/tb_pipelined_lca_adder.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/pipelined_lca_adder.sv
// Pipelined wide adder: one 4-bit lookahead-carry slice per stage, with the slice carry
// registered between stages and a global valid/ready stall.
module lca_stage #(
  parameter int WIDTH = 16,
  parameter int K     = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             adv,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c,
  input  logic [WIDTH-1:0] s,
  output logic [WIDTH-1:0] a_q,
  output logic [WIDTH-1:0] b_q,
  output logic             c_q,
  output logic             c3_q,
  output logic [WIDTH-1:0] s_q
);
  logic [3:0]       p, g, sl;
  logic [4:0]       cy;
  logic [WIDTH-1:0] s_nxt;

  assign p = a[4*K +: 4] ^ b[4*K +: 4];
  assign g = a[4*K +: 4] & b[4*K +: 4];

  // Every carry is a flat sum of products from g/p and the slice carry-in.
  assign cy[0] = c;
  assign cy[1] = g[0] | (p[0] & cy[0]);
  assign cy[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cy[0]);
  assign cy[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cy[0]);
  assign cy[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
               | (p[3] & p[2] & p[1] & p[0] & cy[0]);
  assign sl    = p ^ cy[3:0];

  always_comb begin
    s_nxt          = s;
    s_nxt[4*K +: 4] = sl;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q  <= '0;
      b_q  <= '0;
      c_q  <= 1'b0;
      c3_q <= 1'b0;
      s_q  <= '0;
    end else if (adv) begin
      a_q  <= a;
      b_q  <= b;
      c_q  <= cy[4];
      c3_q <= cy[3];
      s_q  <= s_nxt;
    end
  end
endmodule

module pipelined_lca_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int STAGES = WIDTH / 4;

  // Element 0 is the operand port side; element k+1 is the register bank of stage k.
  logic [WIDTH-1:0] a_p [STAGES+1];
  logic [WIDTH-1:0] b_p [STAGES+1];
  logic [WIDTH-1:0] s_p [STAGES+1];
  logic             c_p [STAGES+1];
  logic             c3_p [STAGES+1];
  logic [STAGES-1:0] vld_pipe;
  logic             adv;

  assign adv       = !out_valid | out_ready;
  assign in_ready  = adv;
  assign out_valid = vld_pipe[STAGES-1];

  assign a_p[0]  = a;
  assign b_p[0]  = b;
  assign s_p[0]  = '0;
  assign c_p[0]  = cin;
  assign c3_p[0] = 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   vld_pipe <= '0;
    else if (adv) vld_pipe <= STAGES'({vld_pipe, in_valid});
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    lca_stage #(.WIDTH(WIDTH), .K(k)) u_stage (
      .clk  (clk),
      .rst_n(rst_n),
      .adv  (adv),
      .a    (a_p[k]),
      .b    (b_p[k]),
      .c    (c_p[k]),
      .s    (s_p[k]),
      .a_q  (a_p[k+1]),
      .b_q  (b_p[k+1]),
      .c_q  (c_p[k+1]),
      .c3_q (c3_p[k+1]),
      .s_q  (s_p[k+1])
    );
  end

  assign sum  = s_p[STAGES];
  assign cout = c_p[STAGES];
  assign ovf  = c3_p[STAGES] ^ c_p[STAGES];
endmodule

// File: tb/tb_pipelined_lca_adder.sv
// Scoreboard bench for pipelined_lca_adder (WIDTH=16): directed vectors, streams,
// random backpressure and mid-flight reset.
module tb_pipelined_lca_adder;
  typedef struct packed {logic [15:0] s; logic c; logic v;} res_t;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, cin, out_valid, out_ready, cout, ovf;
  logic [15:0] a, b, sum;

  int   errors = 0;
  int   checks = 0;
  res_t sb [$];
  res_t exp_next;
  bit   rnd_rdy = 1'b0;
  bit   chk_rdy = 1'b0;
  bit   hold_v  = 1'b0;
  res_t held;

  pipelined_lca_adder #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: everything is sampled at the falling edge, where inputs and outputs are settled
  // for the transfers that happen on the next rising edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_v = 1'b0;
    end else begin
      if (in_valid && in_ready) sb.push_back(exp_next);
      if (chk_rdy) chk("in_ready_eq_adv", {31'b0, in_ready}, {31'b0, !out_valid || out_ready});
      if (hold_v && out_valid) chk("stall_stable", {15'b0, sum, cout, ovf}, {15'b0, held});
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL spurious_output: got sum=%h with empty scoreboard", sum);
        end else begin
          res_t e;
          e = sb.pop_front();
          chk("result", {15'b0, sum, cout, ovf}, {15'b0, e});
        end
      end
      hold_v = out_valid && !out_ready;
      held   = '{s: sum, c: cout, v: ovf};
    end
  end

  always @(posedge clk) if (rnd_rdy) begin
    #1 out_ready = 1'($urandom_range(0, 1));
  end

  task automatic send(input logic [15:0] x, input logic [15:0] y, input logic ci,
                      input res_t e);
    int n = 0;
    in_valid = 1'b1; a = x; b = y; cin = ci; exp_next = e;
    do begin @(negedge clk); n++; end while (!in_ready && n < 200);
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout: in_ready=%b expected 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  function automatic res_t model(input logic [15:0] x, input logic [15:0] y, input logic ci);
    logic [16:0] t;
    res_t r;
    t   = {1'b0, x} + {1'b0, y} + {16'b0, ci};
    r.s = t[15:0];
    r.c = t[16];
    r.v = (x[15] == y[15]) && (t[15] != x[15]);
    return r;
  endfunction

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin @(negedge clk); n++; end
    @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
  endtask

  initial begin
    int    n;
    time   t0;
    logic [15:0] ra, rb;
    logic        rc;
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b1;
    exp_next = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", {31'b0, out_valid}, 0);
    chk("rst_sum", {16'b0, sum}, 0);
    chk("rst_cout", {31'b0, cout}, 0);
    chk("rst_ovf", {31'b0, ovf}, 0);
    chk("rst_in_ready", {31'b0, in_ready}, 1);
    @(posedge clk); #1;

    // Latency of a lone transaction
    send(16'hFFFF, 16'h0001, 1'b0, '{s: 16'h0000, c: 1'b1, v: 1'b0});
    n = 0;
    while (!out_valid && n < 20) begin @(negedge clk); n++; end
    chk("latency", n, 4);
    drain();

    // Directed corner vectors, hand-computed
    send(16'h7FFF, 16'h0000, 1'b1, '{s: 16'h8000, c: 1'b0, v: 1'b1});
    send(16'h8000, 16'h8000, 1'b0, '{s: 16'h0000, c: 1'b1, v: 1'b1});
    send(16'h0F0F, 16'h00F1, 1'b1, '{s: 16'h1001, c: 1'b0, v: 1'b0});
    send(16'h1234, 16'h4321, 1'b0, '{s: 16'h5555, c: 1'b0, v: 1'b0});
    send(16'hFFFF, 16'hFFFF, 1'b1, '{s: 16'hFFFF, c: 1'b1, v: 1'b0});
    send(16'h8000, 16'hFFFF, 1'b0, '{s: 16'h7FFF, c: 1'b1, v: 1'b1});
    send(16'h5555, 16'hAAAA, 1'b1, '{s: 16'h0000, c: 1'b1, v: 1'b0});
    send(16'h0000, 16'h0000, 1'b0, '{s: 16'h0000, c: 1'b0, v: 1'b0});
    drain();

    // Back-to-back stream at full rate
    @(posedge clk); #1;
    t0 = $time;
    for (int i = 0; i < 64; i++) begin
      ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom);
      send(ra, rb, rc, model(ra, rb, rc));
    end
    chk("stream_cycles", 32'(($time - t0) / 10), 64);
    drain();

    // Random backpressure
    rnd_rdy = 1'b1; chk_rdy = 1'b1;
    for (int i = 0; i < 64; i++) begin
      ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom);
      send(ra, rb, rc, model(ra, rb, rc));
    end
    rnd_rdy = 1'b0;
    @(posedge clk); #2 out_ready = 1'b1; chk_rdy = 1'b0;
    drain();

    // Mid-flight reset discards everything in the pipe
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) send(16'(i * 16'h1111), 16'h0101, 1'b0, model(16'(i * 16'h1111), 16'h0101, 1'b0));
    #2;
    chk("pre_rst_out_valid", {31'b0, out_valid}, 1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", {31'b0, out_valid}, 0);
    chk("async_rst_sum", {16'b0, sum}, 0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("post_rst_no_valid", {31'b0, out_valid}, 0);

    // Pipe still works after the reset
    @(posedge clk); #1;
    send(16'h0F0F, 16'h00F1, 1'b1, '{s: 16'h1001, c: 1'b0, v: 1'b0});
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
